lsu_mega: RTL and testbench
===========================

// Module: lsu_mega
// PURPOSE
//  Load/store unit serving the mem_req/mem_we/mem_size controls issued by decoder_mega.
//  Takes one core access, drives a word-wide ready-handshaked data-memory port,
//  stalls the core until completion, returns sign/zero-extended load data.
//  Sits between the core datapath and the data memory / peripheral bus.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles in REQ without mem_ready_i before bus-error abort (>=2)
// PORTS
//  clk_i           in   1   clock; all state on rising edge
//  rst_ni          in   1   asynchronous, active-low reset
//  core_req_i      in   1   access request (decoder mem_req_o)
//  core_we_i       in   1   1=store, 0=load (decoder mem_we_o)
//  core_size_i     in   3   LDST_B/H/W/BU/HU (decoder mem_size_o = funct3)
//  core_addr_i     in   32  byte address
//  core_wd_i       in   32  store data (low bits significant for B/H)
//  core_rd_o       out  32  extended load data, valid when core_req_i & !core_stall_o & !core_we_i
//  core_stall_o    out  1   hold core (PC/regfile write) this cycle
//  bus_err_o       out  1   1-cycle pulse: access aborted by timeout
//  misalign_o      out  1   1-cycle misaligned-access flag (MISALIGN_TRAP_EN only, else 0)
//  mem_req_o       out  1   memory request, held until mem_ready_i
//  mem_we_o        out  1   memory write
//  mem_be_o        out  4   byte enables
//  mem_addr_o      out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wd_o        out  32  lane-replicated store data
//  mem_rd_i        in   32  read word, valid with mem_ready_i
//  mem_ready_i     in   1   memory completes current request this cycle
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state IDLE, timeout counter 0, all registered fields 0;
//    every output 0 (core_stall_o=0 because state IDLE and core_req_i ignored only in reset).
//  - FSM IDLE -> REQ -> IDLE. IDLE: on core_req_i (and not misaligned) latch we,size,addr,be,wd;
//    core_stall_o=1 same cycle; next edge -> REQ. REQ: mem_* driven from latched regs,
//    mem_req_o=1; core_stall_o=!mem_ready_i; on mem_ready_i -> IDLE, counter cleared.
//  - Minimum latency 2 cycles (IDLE accept, REQ with ready). mem_* outputs 0 in IDLE.
//  - core_rd_o = extend(mem_rd_i) in REQ&mem_ready_i using latched size/addr[1:0]; else 0.
//  - be: B -> 4'b0001<<off; H -> 4'b0011<<{off[1],1'b0}; W -> 4'b1111. Sizes 3,6,7 treated as W.
//  - wd: B -> {4{wd[7:0]}}; H -> {2{wd[15:0]}}; W -> wd.
//  - Load extract: B/BU byte at off, sign/zero-extend; H/HU half at off[1]; W full word.
//  - Timeout: counter increments each REQ cycle without ready; at TIMEOUT_CYC-1 and no ready:
//    bus_err_o=1, core_stall_o=0, core_rd_o=0, -> IDLE. Ready on that same cycle wins (no error).
//  - core_req_i dropping while in REQ: access still completes (latched); no cancellation.
//  - Back-to-back: new request accepted in the IDLE cycle right after completion.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with off[0]=1, W with off!=0 in IDLE&core_req_i ->
//    misalign_o=1, core_stall_o=0, no latch, no memory access, stay IDLE.
//  Undefined: no check; misalign_o tied 0; H uses off[1] only, W ignores off.
// STRUCTURE
//  decoder_pkg: LDST_B/H/W/BU/HU constants (existing); add lsu_state_e {LSU_IDLE,LSU_REQ}.
//  Sub-module lsu_load_ext: combinational word->extended data (size, offset, rdata -> rd).
//  Top holds FSM, latches, timeout counter, be/wd generation.
// TESTING
//  1 SW addr=0x100 wd=0xDEADBEEF, ready next cycle -> be=1111, wd=DEADBEEF, stall 1 cycle, 2-cycle access.
//  2 LB addr=0x103 rd=0x80FF_FFFF -> core_rd_o=0xFFFFFF80; LBU -> 0x00000080; SB 0xA5 @0x102 -> be=0100, wd=A5A5A5A5.
//  3 LH addr=0x102 rd=0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; mem_addr_o=0x100.
//  4 ready held low 3 cycles -> mem_req_o/addr stable, stall 4 cycles, release on ready cycle.
//  5 ready never, TIMEOUT_CYC=4 -> bus_err_o pulse in 4th REQ cycle, stall drops, next req accepted.
//  6 rst_ni low mid-REQ -> all outputs 0 immediately; with MISALIGN_TRAP_EN LW @0x101 -> misalign_o=1, mem_req_o=0.

Source files
------------

// File: rtl/lsu_mega_pkg.sv
// Shared load/store encodings and LSU state type for lsu_mega.
// LDST_* values match the decoder's mem_size (funct3) encoding.
package lsu_mega_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_REQ  = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_mega_load_ext.sv
// Combinational load extractor: selects byte/half/word from a read word by offset
// and sign- or zero-extends it according to the access size.
module lsu_mega_load_ext
  import lsu_mega_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rd_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_o     = rdata_i;
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      LDST_B:  rd_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: rd_o = {24'h000000, byte_sel};
      LDST_H:  rd_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: rd_o = {16'h0000, half_sel};
      default: rd_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mega.sv
// Load/store unit: accepts one core access, runs it on a ready-handshaked word memory port
// and stalls the core until completion or timeout. Optional macro MISALIGN_TRAP_EN.
module lsu_mega
  import lsu_mega_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wd_q, wd_d;

  logic [3:0]  be_gen;
  logic [31:0] wd_gen;
  logic        misaligned;
  logic [31:0] ext_rd;

  // Byte enables and lane-replicated store data from the incoming core request.
  always_comb begin
    be_gen = 4'b1111;
    wd_gen = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        be_gen = 4'b0001 << core_addr_i[1:0];
        wd_gen = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be_gen = 4'b0011 << {core_addr_i[1], 1'b0};
        wd_gen = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_gen = 4'b1111;
        wd_gen = core_wd_i;
      end
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (core_size_i)
      LDST_B, LDST_BU: misaligned = 1'b0;
      LDST_H, LDST_HU: misaligned = core_addr_i[0];
      default:         misaligned = (core_addr_i[1:0] != 2'b00);
    endcase
`endif
  end

  lsu_mega_load_ext u_load_ext (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .rdata_i (mem_rd_i),
    .rd_o    (ext_rd)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wd_d         = wd_q;
    core_rd_o    = 32'h0;
    core_stall_o = 1'b0;
    bus_err_o    = 1'b0;
    misalign_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = 32'h0;
    mem_wd_o     = 32'h0;
    case (state_q)
      LSU_IDLE: begin
        // Gating with rst_ni keeps stall/misalign low while reset is asserted.
        if (core_req_i && rst_ni) begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            we_d         = core_we_i;
            size_d       = core_size_i;
            addr_d       = core_addr_i;
            be_d         = be_gen;
            wd_d         = wd_gen;
            core_stall_o = 1'b1;
            state_d      = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = be_q;
        mem_addr_o = {addr_q[31:2], 2'b00};
        mem_wd_o   = wd_q;
        if (mem_ready_i) begin
          core_rd_o = ext_rd;
          cnt_d     = '0;
          state_d   = LSU_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_o = 1'b1;
          cnt_d     = '0;
          state_d   = LSU_IDLE;
        end else begin
          core_stall_o = 1'b1;
          cnt_d        = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_lsu_mega.sv
// Self-checking bench for lsu_mega: directed vectors plus randomized accesses checked
// cycle by cycle against a transaction-level reference model.
module tb_lsu_mega;
  import lsu_mega_pkg::*;

  localparam int TO = 4;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, core_rd_o;
  logic        core_stall_o, bus_err_o, misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i;

  typedef struct packed {
    logic        stall;
    logic        bus_err;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } outs_t;

  int errors = 0;
  int checks = 0;

  lsu_mega #(.TIMEOUT_CYC(TO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic bit is_byte(input logic [2:0] s);
    return (s == 3'd0) || (s == 3'd4);
  endfunction

  function automatic bit is_half(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd5);
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] s, input logic [31:0] a);
    if (is_byte(s)) return 4'(1 << a[1:0]);
    if (is_half(s)) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] s, input logic [31:0] d);
    if (is_byte(s)) return {24'h0, d[7:0]} * 32'h01010101;
    if (is_half(s)) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] bw, hw;
    bw = r >> (8 * a[1:0]);
    hw = r >> (16 * a[1]);
    case (s)
      3'd0:    return 32'($signed(bw[7:0]));
      3'd4:    return {24'h0, bw[7:0]};
      3'd1:    return 32'($signed(hw[15:0]));
      3'd5:    return {16'h0, hw[15:0]};
      default: return r;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] s, input logic [31:0] a);
    if (!TRAP) return 1'b0;
    if (is_byte(s)) return 1'b0;
    if (is_half(s)) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.stall    = core_stall_o;
    o.bus_err  = bus_err_o;
    o.misalign = misalign_o;
    o.mem_req  = mem_req_o;
    o.mem_we   = mem_we_o;
    o.be       = mem_be_o;
    o.addr     = mem_addr_o;
    o.wd       = mem_wd_o;
    o.rd       = core_rd_o;
    return o;
  endfunction

  // One complete access; ready is raised in REQ cycle 'delay' (>= TO means never).
  task automatic run_access(input string name, input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int delay, input bit drop);
    outs_t e, o;
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b0;
    mem_rd_i    = $urandom;
    #1;
    e = '0;
    if (ref_mis(size, addr)) begin
      e.misalign = 1'b1;
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s misalign: got %p want %p", name, o, e);
      end
      core_req_i = 1'b0;
      return;
    end
    e.stall = 1'b1;
    o = observe();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s accept: got %p want %p", name, o, e);
    end
    for (int k = 0; k < TO; k++) begin
      @(negedge clk_i);
      if (drop) core_req_i = 1'b0;
      core_addr_i = $urandom;
      core_wd_i   = $urandom;
      core_size_i = 3'($urandom);
      core_we_i   = 1'($urandom);
      mem_ready_i = (k == delay);
      mem_rd_i    = (k == delay) ? rdata : $urandom;
      #1;
      e         = '0;
      e.mem_req = 1'b1;
      e.mem_we  = we;
      e.be      = ref_be(size, addr);
      e.addr    = {addr[31:2], 2'b00};
      e.wd      = ref_wd(size, wd);
      if (k == delay)        e.rd      = ref_rd(size, addr, rdata);
      else if (k == TO - 1)  e.bus_err = 1'b1;
      else                   e.stall   = 1'b1;
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s req_cyc%0d: got %p want %p", name, k, o, e);
      end
      if (k == delay || k == TO - 1) break;
    end
    core_req_i = 1'b0;
  endtask

  task automatic idle_check(input string name);
    outs_t o;
    @(negedge clk_i);
    core_req_i  = 1'b0;
    mem_ready_i = 1'($urandom);
    mem_rd_i    = $urandom;
    #1;
    o = observe();
    checks++;
    if (o !== outs_t'('0)) begin
      errors++;
      $display("FAIL %s idle: got %p want all zero", name, o);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    outs_t o;
    rst_ni      = 1'b0;
    core_req_i  = 1'b1;
    core_we_i   = 1'b1;
    core_size_i = LDST_W;
    core_addr_i = 32'h0000_0100;
    core_wd_i   = 32'h1234_5678;
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk_i);
    #1;
    o = observe();
    checks++;
    if (o !== outs_t'('0)) begin
      errors++;
      $display("FAIL reset_state: got %p want all zero", o);
    end
    @(negedge clk_i);
    rst_ni     = 1'b1;
    core_req_i = 1'b0;
    idle_check("after_reset");
  endtask

  task automatic test_directed();
    run_access("sw_100",  1'b1, LDST_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    run_access("lb_103",  1'b0, LDST_B,  32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 1'b0);
    run_access("lbu_103", 1'b0, LDST_BU, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 1'b0);
    run_access("sb_102",  1'b1, LDST_B,  32'h0000_0102, 32'h0000_00A5, 32'h0, 0, 1'b0);
    run_access("lh_102",  1'b0, LDST_H,  32'h0000_0102, 32'h0, 32'h8001_1234, 0, 1'b0);
    run_access("lhu_102", 1'b0, LDST_HU, 32'h0000_0102, 32'h0, 32'h8001_1234, 0, 1'b0);
    run_access("sh_100",  1'b1, LDST_H,  32'h0000_0100, 32'hCAFE_7E57, 32'h0, 0, 1'b0);
    run_access("lw_sz7",  1'b0, 3'd7,    32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
    idle_check("directed_end");
  endtask

  task automatic test_wait_states();
    run_access("wait3_lw",  1'b0, LDST_W, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 3, 1'b0);
    run_access("wait2_drop", 1'b1, LDST_H, 32'h0000_0306, 32'h0000_BEEF, 32'h0, 2, 1'b1);
    idle_check("wait_end");
  endtask

  task automatic test_timeout();
    run_access("timeout_lw", 1'b0, LDST_W, 32'h0000_0400, 32'h0, 32'hFFFF_0000, 1000, 1'b0);
    run_access("post_timeout", 1'b0, LDST_BU, 32'h0000_0401, 32'h0, 32'h0000_7F00, 0, 1'b0);
    idle_check("timeout_end");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_access("b2b", 1'(i), LDST_W, 32'h0000_0500 + 32'(4 * i), $urandom, $urandom, 0, 1'b0);
    idle_check("b2b_end");
  endtask

  task automatic test_misalign();
    run_access("lw_101", 1'b0, LDST_W, 32'h0000_0101, 32'h0, 32'hA1B2_C3D4, 0, 1'b0);
    idle_check("misalign_lw_end");
    run_access("lh_103", 1'b0, LDST_H, 32'h0000_0103, 32'h0, 32'h8899_7766, 0, 1'b0);
    idle_check("misalign_lh_end");
  endtask

  task automatic test_reset_mid_req();
    outs_t o;
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = 1'b1;
    core_size_i = LDST_W;
    core_addr_i = 32'h0000_0600;
    core_wd_i   = 32'h5555_AAAA;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_pre: got mem_req=%b want 1", mem_req_o);
    end
    rst_ni = 1'b0;
    #1;
    o = observe();
    checks++;
    if (o !== outs_t'('0)) begin
      errors++;
      $display("FAIL mid_req_reset: got %p want all zero", o);
    end
    @(negedge clk_i);
    rst_ni     = 1'b1;
    core_req_i = 1'b0;
    idle_check("mid_req_release");
    run_access("post_reset_lw", 1'b0, LDST_W, 32'h0000_0604, 32'h0, 32'h0102_0304, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] sizes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 60; i++) begin
      run_access("rand", 1'($urandom), sizes[$urandom_range(0, 7)], $urandom, $urandom,
                 $urandom, int'($urandom_range(0, TO + 1)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_check("rand_gap");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_misalign();
    test_reset_mid_req();
    test_random();
    idle_check("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
